// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and registers
// pc/pc+4/instruction for ID; a hold buffer and a drain state cover stalls and redirects.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_INS  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  input  logic        control_j,
  input  logic [31:0] pc_j,
  input  logic        stall,
  output logic [31:0] pipe_pc,
  output logic [31:0] pipe_pc4,
  output logic [31:0] pipe_data,
  output logic        pipe_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] redir_pc_r, redir_pc_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_data_r, buf_data_s;
  logic [31:0] pipe_pc_r, pipe_pc_s;
  logic [31:0] pipe_pc4_r, pipe_pc4_s;
  logic [31:0] pipe_data_r, pipe_data_s;
  logic        pipe_valid_r, pipe_valid_s;
  logic        imem_req_r, imem_req_s;
  logic        deliver_s;
  logic [31:0] deliver_pc_s;
  logic [31:0] deliver_data_s;

  // Fetch FSM next-state: decides PC movement and whether an instruction is delivered.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    redir_pc_s     = redir_pc_r;
    buf_pc_s       = buf_pc_r;
    buf_data_s     = buf_data_r;
    deliver_s      = 1'b0;
    deliver_pc_s   = pc_r;
    deliver_data_s = imem_data;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          if (control_j) begin
            pc_s = pc_j;
          end else if (stall) begin
            buf_data_s = imem_data;
            buf_pc_s   = pc_r;
            pc_s       = pc_r + 32'd4;
            state_s    = HOLD;
          end else begin
            deliver_s = 1'b1;
            pc_s      = pc_r + 32'd4;
          end
        end else if (control_j) begin
          redir_pc_s = pc_j;
          state_s    = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the abandoned path and is always discarded.
        if (imem_ready) begin
          pc_s    = control_j ? pc_j : redir_pc_r;
          state_s = FETCH;
        end else if (control_j) begin
          redir_pc_s = pc_j;
        end else begin
          state_s = DRAIN;
        end
      end
      HOLD: begin
        if (control_j) begin
          pc_s    = pc_j;
          state_s = FETCH;
        end else if (!stall) begin
          deliver_s      = 1'b1;
          deliver_pc_s   = buf_pc_r;
          deliver_data_s = buf_data_r;
          state_s        = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    imem_req_s = (state_s == FETCH) || (state_s == DRAIN);
  end

  // Pipe register next values: flush beats stall, stall beats load, otherwise a bubble.
  always_comb begin
    pipe_pc_s    = pipe_pc_r;
    pipe_pc4_s   = pipe_pc4_r;
    pipe_data_s  = pipe_data_r;
    pipe_valid_s = pipe_valid_r;
    if (control_j) begin
      pipe_data_s  = NOP_INS;
      pipe_valid_s = 1'b0;
    end else if (stall) begin
      pipe_valid_s = pipe_valid_r;
    end else if (deliver_s) begin
      pipe_pc_s    = deliver_pc_s;
      pipe_pc4_s   = deliver_pc_s + 32'd4;
      pipe_data_s  = deliver_data_s;
      pipe_valid_s = 1'b1;
    end else begin
      pipe_data_s  = NOP_INS;
      pipe_valid_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_r      <= IDLE;
      pc_r         <= RESET_PC;
      redir_pc_r   <= RESET_PC;
      buf_pc_r     <= 32'd0;
      buf_data_r   <= NOP_INS;
      pipe_pc_r    <= 32'd0;
      pipe_pc4_r   <= 32'd0;
      pipe_data_r  <= NOP_INS;
      pipe_valid_r <= 1'b0;
      imem_req_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      redir_pc_r   <= redir_pc_s;
      buf_pc_r     <= buf_pc_s;
      buf_data_r   <= buf_data_s;
      pipe_pc_r    <= pipe_pc_s;
      pipe_pc4_r   <= pipe_pc4_s;
      pipe_data_r  <= pipe_data_s;
      pipe_valid_r <= pipe_valid_s;
      imem_req_r   <= imem_req_s;
    end
  end

  assign imem_req   = imem_req_r;
  assign imem_addr  = pc_r;
  assign pipe_pc    = pipe_pc_r;
  assign pipe_pc4   = pipe_pc4_r;
  assign pipe_data  = pipe_data_r;
  assign pipe_valid = pipe_valid_r;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, zero-wait stream, wait states, stall/hold,
// redirects in FETCH/DRAIN/HOLD, PC wrap and mid-run reset.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'd400;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        control_j;
  logic [31:0] pc_j;
  logic        stall;
  logic [31:0] pipe_pc;
  logic [31:0] pipe_pc4;
  logic [31:0] pipe_data;
  logic        pipe_valid;

  int checks_s;
  int failures_s;

  if_stage #(.RESET_PC(RST_PC), .NOP_INS(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .control_j(control_j), .pc_j(pc_j), .stall(stall),
    .pipe_pc(pipe_pc), .pipe_pc4(pipe_pc4),
    .pipe_data(pipe_data), .pipe_valid(pipe_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: a fixed word at 400, otherwise an address-derived pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd400) return 32'h0070_0613;
    else return a ^ 32'hA5A5_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_s++;
    if (obs !== exp) begin
      failures_s++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pipe(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] data);
    check_eq({tag, ".valid"}, {31'd0, pipe_valid}, {31'd0, v});
    check_eq({tag, ".pc"}, pipe_pc, pc);
    check_eq({tag, ".pc4"}, pipe_pc4, pc + 32'd4);
    check_eq({tag, ".data"}, pipe_data, data);
  endtask

  task automatic chk_bubble(input string tag);
    check_eq({tag, ".valid"}, {31'd0, pipe_valid}, 32'd0);
    check_eq({tag, ".data"}, pipe_data, NOP);
  endtask

  task automatic chk_mem(input string tag, input logic req, input logic [31:0] addr);
    check_eq({tag, ".req"}, {31'd0, imem_req}, {31'd0, req});
    check_eq({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_reset(input string tag);
    check_eq({tag, ".pc"}, pipe_pc, 32'd0);
    check_eq({tag, ".pc4"}, pipe_pc4, 32'd0);
    check_eq({tag, ".data"}, pipe_data, NOP);
    check_eq({tag, ".valid"}, {31'd0, pipe_valid}, 32'd0);
    chk_mem(tag, 1'b0, RST_PC);
  endtask

  initial begin
    checks_s   = 0;
    failures_s = 0;
    reset_n    = 1'b1;
    imem_ready = 1'b1;
    control_j  = 1'b0;
    pc_j       = 32'd0;
    stall      = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk_reset("rst");
    reset_n = 1'b0;

    // IDLE cycle, then zero-wait stream 400, 404
    step(); chk_bubble("idle"); chk_mem("idle", 1'b1, 32'd400);
    step(); chk_pipe("f400", 1'b1, 32'd400, 32'h0070_0613); chk_mem("f400", 1'b1, 32'd404);

    // Two wait cycles on 404: one bubble per wait cycle, address held
    imem_ready = 1'b0;
    step(); chk_bubble("w1"); chk_mem("w1", 1'b1, 32'd404);
    step(); chk_bubble("w2"); chk_mem("w2", 1'b1, 32'd404);
    imem_ready = 1'b1;
    step(); chk_pipe("f404", 1'b1, 32'd404, mem_word(32'd404)); chk_mem("f404", 1'b1, 32'd408);

    // Stall for 3 cycles while 408 completes; pipe holds 404, HOLD drops req
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_pipe("stl", 1'b1, 32'd404, mem_word(32'd404)); chk_mem("stl", 1'b0, 32'd412);
    end
    stall = 1'b0;
    step(); chk_pipe("f408", 1'b1, 32'd408, mem_word(32'd408)); chk_mem("f408", 1'b1, 32'd412);
    step(); chk_pipe("f412", 1'b1, 32'd412, mem_word(32'd412)); chk_mem("f412", 1'b1, 32'd416);

    // Redirect during a zero-wait fetch: data dropped, pipe flushed, pc unchanged
    control_j = 1'b1; pc_j = 32'd100;
    step(); chk_pipe("jz", 1'b0, 32'd412, NOP); chk_mem("jz", 1'b1, 32'd100);
    control_j = 1'b0;
    step(); chk_pipe("f100", 1'b1, 32'd100, mem_word(32'd100)); chk_mem("f100", 1'b1, 32'd104);

    // Redirect while waiting: DRAIN, second redirect overwrites the target
    imem_ready = 1'b0; control_j = 1'b1; pc_j = 32'd200;
    step(); chk_pipe("jw", 1'b0, 32'd100, NOP); chk_mem("jw", 1'b1, 32'd104);
    pc_j = 32'd300;
    step(); chk_bubble("dr1"); chk_mem("dr1", 1'b1, 32'd104);
    control_j = 1'b0; imem_ready = 1'b1;
    step(); chk_bubble("dr2"); chk_mem("dr2", 1'b1, 32'd300);
    step(); chk_pipe("f300", 1'b1, 32'd300, mem_word(32'd300)); chk_mem("f300", 1'b1, 32'd304);

    // Redirect in HOLD with stall still high: buffer dropped, flush beats stall
    stall = 1'b1;
    step(); chk_pipe("h304", 1'b1, 32'd300, mem_word(32'd300)); chk_mem("h304", 1'b0, 32'd308);
    control_j = 1'b1; pc_j = 32'd500;
    step(); chk_pipe("jh", 1'b0, 32'd300, NOP); chk_mem("jh", 1'b1, 32'd500);
    control_j = 1'b0; stall = 1'b0;
    step(); chk_pipe("f500", 1'b1, 32'd500, mem_word(32'd500)); chk_mem("f500", 1'b1, 32'd504);

    // PC wrap at the top of the address space
    control_j = 1'b1; pc_j = 32'hFFFF_FFFC;
    step(); chk_bubble("jwrap"); chk_mem("jwrap", 1'b1, 32'hFFFF_FFFC);
    control_j = 1'b0;
    step(); chk_pipe("ftop", 1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
    check_eq("ftop.pc4wrap", pipe_pc4, 32'd0); chk_mem("ftop", 1'b1, 32'd0);
    step(); chk_pipe("f0", 1'b1, 32'd0, mem_word(32'd0)); chk_mem("f0", 1'b1, 32'd4);

    // Reset during an outstanding request
    imem_ready = 1'b0; reset_n = 1'b1;
    step(); chk_reset("rst2");
    reset_n = 1'b0;
    step(); chk_bubble("idle2"); chk_mem("idle2", 1'b1, 32'd400);

    $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
    $finish;
  end

endmodule
